// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, addresses instruction memory and registers the returned word into IR.
// Optional build macro FETCH_JUMP_EN resolves unconditional jumps inside fetch.
module instr_fetch #(
    parameter logic [4:0] RESET_ADR = 5'd0,
    parameter logic [4:0] LAST_ADR  = 5'd19,
    parameter logic [4:0] JUMP_OP   = 5'b10010
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic [4:0]  o_instruction_adr,
    input  logic [15:0] i_instruction,
    input  logic        i_stall,
    input  logic        i_redirect_valid,
    input  logic [4:0]  i_redirect_adr,
    output logic [15:0] o_ir,
    output logic [4:0]  o_ir_pc,
    output logic        o_ir_valid,
    output logic        o_halted
);

`ifdef FETCH_JUMP_EN
    localparam bit JUMP_EN = 1'b1;
`else
    localparam bit JUMP_EN = 1'b0;
`endif

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [4:0]  r_pc;
    logic [4:0]  w_pc_next;
    logic [15:0] r_ir;
    logic [15:0] w_ir_next;
    logic [4:0]  r_ir_pc;
    logic [4:0]  w_ir_pc_next;
    logic        r_ir_valid;
    logic        w_ir_valid_next;
    logic        w_jump_take;

    // Constant-folds to zero when the fetch-stage jump is not built.
    assign w_jump_take = JUMP_EN && (i_instruction[15:11] == JUMP_OP);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= RUN;
            r_pc       <= RESET_ADR;
            r_ir       <= 16'h0000;
            r_ir_pc    <= 5'd0;
            r_ir_valid <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_pc       <= w_pc_next;
            r_ir       <= w_ir_next;
            r_ir_pc    <= w_ir_pc_next;
            r_ir_valid <= w_ir_valid_next;
        end
    end

    // Redirect beats stall; a redirect flushes IR validity but leaves the IR contents alone.
    always_comb begin
        w_state_next    = r_state;
        w_pc_next       = r_pc;
        w_ir_next       = r_ir;
        w_ir_pc_next    = r_ir_pc;
        w_ir_valid_next = r_ir_valid;
        if (i_redirect_valid) begin
            w_pc_next       = i_redirect_adr;
            w_ir_valid_next = 1'b0;
            w_state_next    = RUN;
        end else if (!i_stall) begin
            case (r_state)
                RUN: begin
                    if (w_jump_take) begin
                        w_pc_next       = i_instruction[10:6];
                        w_ir_valid_next = 1'b0;
                    end else begin
                        w_ir_next       = i_instruction;
                        w_ir_pc_next    = r_pc;
                        w_ir_valid_next = 1'b1;
                        if (r_pc == LAST_ADR) begin
                            w_state_next = HALT;
                        end else begin
                            w_pc_next = r_pc + 5'd1;
                        end
                    end
                end
                HALT: begin
                    w_ir_valid_next = 1'b0;
                end
                default: begin
                    w_state_next = RUN;
                end
            endcase
        end
    end

    assign o_instruction_adr = r_pc;
    assign o_ir              = r_ir;
    assign o_ir_pc           = r_ir_pc;
    assign o_ir_valid        = r_ir_valid;
    assign o_halted          = (r_state == HALT);

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Fetch stage of the 16-bit CPU: owns the program counter, drives the 5-bit address into the combinational instruction memory, and registers the returned 16-bit word into an instruction register for decode. It sits between `InstructionMem` and the decode/execute logic. It handles stall and execute-stage redirects, optionally resolves unconditional `jump` in fetch, and halts after the last program address.

## Interface
Parameters:
- `RESET_ADR`, 5'd0: PC value loaded on reset.
- `LAST_ADR`, 5'd19: address of the final program word. After it is delivered, fetch halts.
- `JUMP_OP`, 5'b10010: opcode (bits [15:11]) treated as unconditional jump. Target field is bits [10:6].

Ports:
- `clk` in 1: the only clock. All state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `instruction_adr` out 5: fetch address to the instruction memory. Combinationally equals the PC register.
- `instruction` in 16: word returned by memory, valid in the same cycle as `instruction_adr`.
- `stall` in 1: decode cannot accept. Hold everything.
- `redirect_valid` in 1: execute-stage control transfer.
- `redirect_adr` in 5: target of the redirect.
- `ir` out 16: registered instruction.
- `ir_pc` out 5: address `ir` was fetched from.
- `ir_valid` out 1: `ir` holds a live instruction. Decode consumes it in a cycle where `ir_valid && !stall`.
- `halted` out 1: high while in HALT.

## Operation
- State machine has two states, RUN and HALT. Registers: `pc`, `ir`, `ir_pc`, `ir_valid`, state.
- Reset values: state=RUN, `pc`=RESET_ADR, `ir`=16'h0000 (nop), `ir_pc`=0, `ir_valid`=0, `halted`=0.
- Priority per cycle, highest first: `rst` > `redirect_valid` > `stall` > normal fetch.
- Redirect, in any state and regardless of `stall`:
  - `pc`<=`redirect_adr`, `ir_valid`<=0 (flush), state<=RUN.
  - `ir` and `ir_pc` hold.
- Stall, without redirect: `pc`, `ir`, `ir_pc`, `ir_valid` and state all hold.
- Normal fetch in RUN:
  - `ir`<=`instruction`, `ir_pc`<=`pc`, `ir_valid`<=1.
  - `pc`<=`pc`+1, modulo 32, so 31 wraps to 0.
  - If `pc`==LAST_ADR: state<=HALT and `pc` holds. The LAST_ADR word is still delivered with `ir_valid`=1.
- Jump resolved in fetch (only when compiled in, see Configuration):
  - Applies when `instruction[15:11]`==JUMP_OP.
  - `pc`<=`instruction[10:6]`, `ir_valid`<=0 (bubble; the jump is not forwarded), state stays RUN.
  - This overrides the LAST_ADR halt check.
- HALT, without redirect:
  - `pc` holds and no new word is loaded.
  - `ir_valid`<=0 in the first cycle where `stall`=0, so the last word is consumed exactly once.
  - Exit only via `rst` or `redirect_valid`.
- Address arithmetic is 5-bit unsigned, with no overflow flag.

## Timing
- `instruction_adr` is valid combinationally from `pc` in the same cycle. Memory latency is 0, so `ir` is loaded on the next edge.
- Fetch-to-`ir` latency is 1 cycle. Throughput is 1 word per cycle when not stalled.
- First `ir_valid`=1 appears 1 cycle after `rst` deasserts.
- A redirect costs 1 bubble: `ir_valid`=0 in the cycle after the redirect edge, then the target word appears one cycle later.
- A fetch-resolved jump costs 1 bubble.
- A redirect coincident with a fetched jump: the redirect wins.
- `halted` is registered and rises on the edge that loads LAST_ADR into `ir`.

## Configuration
- `FETCH_JUMP_EN` defined: the fetch-stage jump resolution described above is built.
- Not defined: a jump word is treated as an ordinary instruction. It is loaded into `ir` with `ir_valid`=1 and `pc` increments; execute must issue `redirect_valid`. The LAST_ADR halt check then applies to jump words too.

## Test plan
- Reset: hold `rst`=1 for 2 cycles. Required response:
  - During reset: `instruction_adr`=0, `ir`=0, `ir_valid`=0, `halted`=0.
  - First cycle after release: `ir`=mem[0], `ir_pc`=0, `ir_valid`=1, `instruction_adr`=1.
- Sequential fetch, LAST_ADR=19, no stalls:
  - `ir_pc` steps 0,1,2,…,19 with `ir_valid`=1 on each.
  - Then `halted`=1, `ir_valid`=0, `instruction_adr`=19 held.
- Stall: assert `stall` for 3 cycles while `ir_pc`=4.
  - `ir`, `ir_pc`=4 and `instruction_adr`=5 are frozen.
  - Fetch resumes with `ir_pc`=5 on the first unstalled edge.
- Jump, with `FETCH_JUMP_EN` and mem[6]={JUMP_OP,5'd2,6'b0}:
  - After `ir_pc`=5: one `ir_valid`=0 cycle, then `ir_pc`=2.
  - Without the macro: `ir_pc`=6 is valid and `ir_pc`=7 follows.
- Redirect during stall and HALT:
  - `redirect_valid`=1, `redirect_adr`=30, issued with `stall`=1 while halted.
  - Next cycle: `halted`=0, `ir_valid`=0, `instruction_adr`=30.
  - Then `ir_pc` steps 30, 31, 0, 1 (wrap-around).
- Redirect coincident with a fetched jump to 2, `redirect_adr`=9: next `instruction_adr`=9.
